// File: rtl/cswap_lanes.sv
`default_nettype none
// ============================================================================
// Module   : cswap_lanes
// Purpose  : Multi-lane registered controlled-swap (Fredkin) stage with
//            valid/ready flow control and a saturating swap counter.
//            Each lane routes its two operands straight or crossed. The swap
//            decision comes from the lane control bit, an unsigned
//            compare-and-swap (min to A, max to B), or a forced pass/swap.
// Ports    : clk, rst_n           - clock, synchronous active-low reset
//            mode                 - 00 ctrl, 01 cmp ascending, 10 pass, 11 swap
//            in_valid/in_ready    - input handshake
//            in_ctrl/in_a/in_b    - per-lane control bit and operands
//            out_valid/out_ready  - output handshake
//            out_ctrl/out_a/out_b - registered control and lane results
//            out_swp              - per-lane swapped flag
//            swap_cnt             - saturating count of swapped lanes
// Revision : 1.0 - initial release
// ============================================================================
module cswap_lanes #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_ctrl,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_ctrl,
  output logic [LANES*WIDTH-1:0] out_a,
  output logic [LANES*WIDTH-1:0] out_b,
  output logic [LANES-1:0]       out_swp,
  output logic [CNT_W-1:0]       swap_cnt
);

  localparam logic [1:0] c_MODE_CTRL = 2'b00;
  localparam logic [1:0] c_MODE_CMP  = 2'b01;
  localparam logic [1:0] c_MODE_PASS = 2'b10;

  // Sum width holds the counter plus one beat's popcount with one carry bit,
  // so saturation is detected without any wrap.
  localparam int c_POP_W = $clog2(LANES + 1);
  localparam int c_SUM_W = ((CNT_W > c_POP_W) ? CNT_W : c_POP_W) + 1;
  localparam logic [c_SUM_W-1:0] c_CNT_MAX = {{(c_SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic                   r_valid;
  logic [LANES-1:0]       r_ctrl;
  logic [LANES*WIDTH-1:0] r_a;
  logic [LANES*WIDTH-1:0] r_b;
  logic [LANES-1:0]       r_swp;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_accept;
  logic [LANES-1:0]       w_swap;
  logic [LANES*WIDTH-1:0] w_a_nxt;
  logic [LANES*WIDTH-1:0] w_b_nxt;
  logic [c_SUM_W-1:0]     w_pop;
  logic [c_SUM_W-1:0]     w_sum;
  logic [CNT_W-1:0]       w_cnt_nxt;

  // Ready is forced low during reset so no beat is taken while state clears.
  assign in_ready = rst_n & (~r_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] w_la;
    logic [WIDTH-1:0] w_lb;
    logic             w_s;

    assign w_la = in_a[i*WIDTH +: WIDTH];
    assign w_lb = in_b[i*WIDTH +: WIDTH];

    always_comb begin
      w_s = 1'b0;
      case (mode)
        c_MODE_CTRL: w_s = in_ctrl[i];
        c_MODE_CMP:  w_s = (w_la > w_lb);   // equal operands stay put
        c_MODE_PASS: w_s = 1'b0;
        default:     w_s = 1'b1;
      endcase
    end

    assign w_swap[i]                 = w_s;
    assign w_a_nxt[i*WIDTH +: WIDTH] = w_s ? w_lb : w_la;
    assign w_b_nxt[i*WIDTH +: WIDTH] = w_s ? w_la : w_lb;
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + c_SUM_W'(w_swap[i]);
    end
  end

  assign w_sum     = c_SUM_W'(r_cnt) + w_pop;
  assign w_cnt_nxt = (w_sum > c_CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  // A push with a simultaneous pop simply overwrites the register, giving
  // one beat per cycle with no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_swp   <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_ctrl  <= in_ctrl;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_swp   <= w_swap;
      r_cnt   <= w_cnt_nxt;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_ctrl  = r_ctrl;
  assign out_a     = r_a;
  assign out_b     = r_b;
  assign out_swp   = r_swp;
  assign swap_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cswap_lanes.sv
`default_nettype none
// ============================================================================
// Module   : tb_cswap_lanes
// Purpose  : Self-checking bench for cswap_lanes. A main instance
//            (4 lanes x 8 bits, 4-bit counter) is tracked by a scoreboard;
//            a 1-lane 1-bit instance covers the full Fredkin truth table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cswap_lanes;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [LANES-1:0]       c;
    logic [LANES*WIDTH-1:0] a;
    logic [LANES*WIDTH-1:0] b;
    logic [LANES-1:0]       s;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [1:0]             mode;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES-1:0]       in_ctrl;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_ctrl;
  logic [LANES*WIDTH-1:0] out_a;
  logic [LANES*WIDTH-1:0] out_b;
  logic [LANES-1:0]       out_swp;
  logic [CNT_W-1:0]       swap_cnt;

  logic [1:0]  mode1;
  logic        in_valid1;
  logic        in_ready1;
  logic [0:0]  in_ctrl1;
  logic [0:0]  in_a1;
  logic [0:0]  in_b1;
  logic        out_valid1;
  logic        out_ready1;
  logic [0:0]  out_ctrl1;
  logic [0:0]  out_a1;
  logic [0:0]  out_b1;
  logic [0:0]  out_swp1;
  logic [15:0] swap_cnt1;

  cswap_lanes #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_a(out_a), .out_b(out_b),
    .out_swp(out_swp), .swap_cnt(swap_cnt)
  );

  cswap_lanes #(.LANES(1), .WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode1),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_ctrl(in_ctrl1), .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_ctrl(out_ctrl1), .out_a(out_a1), .out_b(out_b1),
    .out_swp(out_swp1), .swap_cnt(swap_cnt1)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_cnt = 0;
  bit    mon_en  = 1'b0;
  beat_t q[$];
  beat_t m_exp;
  beat_t m_got;
  logic  m_rdy;

  // Reference behaviour of one beat, written lane by lane from the mode table.
  function automatic beat_t model(input logic [1:0] m, input logic [LANES-1:0] c,
                                  input logic [LANES*WIDTH-1:0] a,
                                  input logic [LANES*WIDTH-1:0] b);
    beat_t r;
    logic [WIDTH-1:0] la, lb;
    logic s;
    r.c = c;
    r.a = '0;
    r.b = '0;
    r.s = '0;
    for (int l = 0; l < LANES; l++) begin
      la = a[l*WIDTH +: WIDTH];
      lb = b[l*WIDTH +: WIDTH];
      if (m == 2'b00)      s = c[l];
      else if (m == 2'b01) s = (la > lb);
      else if (m == 2'b10) s = 1'b0;
      else                 s = 1'b1;
      r.s[l] = s;
      r.a[l*WIDTH +: WIDTH] = s ? lb : la;
      r.b[l*WIDTH +: WIDTH] = s ? la : lb;
    end
    return r;
  endfunction

  // Scoreboard for the main instance, evaluated mid-cycle before the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      m_rdy = rst_n && ((q.size() == 0) || out_ready);
      n_tests++;
      if (out_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL sb_out_valid: got %b want %b at %0t", out_valid, (q.size() != 0), $time);
      end
      n_tests++;
      if (in_ready !== m_rdy) begin
        n_fail++;
        $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, m_rdy, $time);
      end
      n_tests++;
      if (swap_cnt !== CNT_W'(exp_cnt)) begin
        n_fail++;
        $display("FAIL sb_swap_cnt: got %0d want %0d at %0t", swap_cnt, exp_cnt, $time);
      end
      if ((q.size() != 0) && out_ready) begin
        m_exp = q.pop_front();
        m_got = {out_ctrl, out_a, out_b, out_swp};
        n_tests++;
        if (m_got !== m_exp) begin
          n_fail++;
          $display("FAIL sb_beat: got %h want %h at %0t", m_got, m_exp, $time);
        end
      end
      if (!rst_n) begin
        q.delete();
        exp_cnt = 0;
      end else if (in_valid && m_rdy) begin
        m_exp = model(mode, in_ctrl, in_a, in_b);
        q.push_back(m_exp);
        exp_cnt = exp_cnt + $countones(m_exp.s);
        if (exp_cnt > CMAX) exp_cnt = CMAX;
      end
    end
  end

  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || {out_ctrl, out_a, out_b, out_swp} !== '0 ||
          swap_cnt !== '0 || in_ready !== 1'b0 || out_valid1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset: got v=%b data=%h cnt=%0d rdy=%b v1=%b want all zero",
                 out_valid, {out_ctrl, out_a, out_b, out_swp}, swap_cnt, in_ready, out_valid1);
      end
    end
    @(posedge clk); #1;
    mon_en = 1'b1; rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_fredkin;
    logic [3:0] e1[$];
    logic [3:0] x1, g1;
    logic c, a, b;
    do_reset;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k < 8) begin
        c = 1'(k >> 2); a = 1'(k >> 1); b = 1'(k);
        in_valid1 = 1'b1; in_ctrl1 = c; in_a1 = a; in_b1 = b;
        e1.push_back({c, (c ? b : a), (c ? a : b), c});
      end else begin
        in_valid1 = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        x1 = e1.pop_front();
        g1 = {out_ctrl1, out_a1, out_b1, out_swp1};
        n_tests++;
        if (out_valid1 !== 1'b1 || g1 !== x1) begin
          n_fail++;
          $display("FAIL fredkin_%0d: got v=%b %b want v=1 %b", k - 1, out_valid1, g1, x1);
        end
      end
    end
    n_tests++;
    if (swap_cnt1 !== 16'd4) begin
      n_fail++;
      $display("FAIL fredkin_cnt: got %0d want 4", swap_cnt1);
    end
  endtask

  task automatic test_cmpswap;
    do_reset;
    @(posedge clk); #1;
    out_ready = 1'b1; mode = 2'b01; in_valid = 1'b1; in_ctrl = 4'b1111;
    in_a = 32'h0000_0590; in_b = 32'h0000_0510;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_a !== 32'h0000_0510 || out_b !== 32'h0000_0590 ||
        out_swp !== 4'b0001 || out_ctrl !== 4'b1111 || swap_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL cmpswap: got v=%b a=%h b=%h swp=%b ctrl=%b cnt=%0d want 1 00000510 00000590 0001 1111 1",
               out_valid, out_a, out_b, out_swp, out_ctrl, swap_cnt);
    end
  endtask

  task automatic test_backpressure;
    beat_t ea;
    ea = model(2'b00, 4'b0101, 32'h1122_3344, 32'hAABB_CCDD);
    do_reset;
    @(posedge clk); #1;
    out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1;
    in_ctrl = 4'b0101; in_a = 32'h1122_3344; in_b = 32'hAABB_CCDD;
    @(posedge clk); #1;
    in_ctrl = 4'b0011; in_a = 32'h0102_0304; in_b = 32'h0A0B_0C0D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || {out_ctrl, out_a, out_b, out_swp} !== ea ||
          in_ready !== 1'b0 || swap_cnt !== 4'd2) begin
        n_fail++;
        $display("FAIL stall_%0d: got v=%b %h rdy=%b cnt=%0d want v=1 %h rdy=0 cnt=2",
                 k, out_valid, {out_ctrl, out_a, out_b, out_swp}, in_ready, swap_cnt, ea);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      mode = 2'($urandom_range(0, 3));
      in_ctrl = 4'($urandom); in_a = $urandom; in_b = $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_saturation;
    int seq[5] = '{4, 8, 12, 15, 15};
    do_reset;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; mode = 2'b11;
      if (k < 5) begin
        in_valid = 1'b1; in_ctrl = 4'($urandom); in_a = $urandom; in_b = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        n_tests++;
        if (swap_cnt !== CNT_W'(seq[k-1])) begin
          n_fail++;
          $display("FAIL sat_%0d: got %0d want %0d", k - 1, swap_cnt, seq[k-1]);
        end
      end
    end
  endtask

  task automatic test_modes;
    do_reset;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom_range(0, 3));
      in_ctrl   = 4'($urandom);
      in_a      = $urandom;
      in_b      = (k % 7 == 0) ? in_a : $urandom;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_midreset;
    do_reset;
    @(posedge clk); #1;
    out_ready = 1'b0; mode = 2'b11; in_valid = 1'b1;
    in_ctrl = 4'b1010; in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || swap_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL midrst_pre: got v=%b cnt=%0d want v=1 cnt=4", out_valid, swap_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || swap_cnt !== '0 || out_a !== '0 || out_b !== '0) begin
      n_fail++;
      $display("FAIL midrst_post: got v=%b cnt=%0d a=%h b=%h want all zero",
               out_valid, swap_cnt, out_a, out_b);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; mode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    in_ctrl = 4'b1111; in_a = 32'hFFFF_FFFF; in_b = 32'h5555_AAAA;
    mode1 = 2'b00; in_valid1 = 1'b1; out_ready1 = 1'b1;
    in_ctrl1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b0;
    test_reset;
    test_fredkin;
    test_cmpswap;
    test_backpressure;
    test_saturation;
    test_modes;
    test_midreset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
